// File: rtl/dp_result_collector.sv
// dp_result_collector
// Terminal stage of the iterative series datapath. Finished results (live and
// not recirculating) are queued in a small show-ahead FIFO and handed to the
// consumer over valid/ready. The upstream pipeline cannot stall, so a result
// arriving at a full FIFO with no same-cycle pop is dropped and counted.
// The head entry is held in its own register so out_* come straight from
// flops with no path from in_*.

module dp_result_collector #(
  parameter int DEPTH = 4,
  parameter bit SAT   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              in_sum,
  input  logic                     in_overflow,
  input  logic [2:0]               in_i,
  input  logic                     in_flag_next,
  input  logic                     in_valid,
  output logic [31:0]              out_data,
  output logic                     out_overflow,
  output logic [2:0]               out_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     drop_err,
  input  logic                     clr_err,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]   SAT_VAL  = 32'h7FFF_FFFF;

  // entry layout: {iteration index, overflow, data}
  logic [35:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [35:0]   head_q, head_d;
  logic          drop_err_q, drop_err_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic          res, pop, push, drop;
  logic [35:0]   wr_entry;

  assign out_valid    = (count_q != '0);
  assign full         = (count_q == FULL_CNT);
  assign count        = count_q;
  assign out_data     = head_q[31:0];
  assign out_overflow = head_q[32];
  assign out_i        = head_q[35:33];
  assign drop_err     = drop_err_q;
  assign drop_cnt     = drop_cnt_q;

  // Handshake qualifiers and next-state for pointers, occupancy, head and drop status.
  always_comb begin
    res      = in_valid & ~in_flag_next;
    pop      = out_valid & out_ready;
    push     = res & (~full | pop);
    drop     = res & full & ~pop;
    wr_entry = {in_i, in_overflow, (SAT && in_overflow) ? SAT_VAL : in_sum};

    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The new head may be the slot being written this very cycle (push into
    // an empty FIFO, or push+pop with a single entry), so bypass it.
    if (push && (wr_ptr_q == rd_ptr_d)) head_d = wr_entry;
    else                                 head_d = mem_q[rd_ptr_d];

    drop_err_d = drop_err_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_err) begin
      drop_err_d = drop;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      drop_err_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Control and head register, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      drop_err_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      drop_err_q <= drop_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage array; contents survive reset since only the pointers matter.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: tb/tb_dp_result_collector.sv
// Bench for dp_result_collector: two instances (saturating and raw) share the
// same stimulus; a queue-based model predicts outputs checked every cycle,
// plus literal expectations at the directed test points.

module tb_dp_result_collector;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_sum;
  logic        in_overflow;
  logic [2:0]  in_i;
  logic        in_flag_next;
  logic        in_valid;
  logic        out_ready;
  logic        clr_err;

  logic [31:0] out_data,  out_data0;
  logic        out_overflow, out_overflow0;
  logic [2:0]  out_i, out_i0;
  logic        out_valid, out_valid0;
  logic [2:0]  count, count0;
  logic        full, full0;
  logic        drop_err, drop_err0;
  logic [7:0]  drop_cnt, drop_cnt0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dp_result_collector #(.DEPTH(DEPTH), .SAT(1'b1)) dut (
    .clk(clk), .rst(rst), .in_sum(in_sum), .in_overflow(in_overflow), .in_i(in_i),
    .in_flag_next(in_flag_next), .in_valid(in_valid), .out_data(out_data),
    .out_overflow(out_overflow), .out_i(out_i), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .full(full), .drop_err(drop_err),
    .clr_err(clr_err), .drop_cnt(drop_cnt));

  dp_result_collector #(.DEPTH(DEPTH), .SAT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_sum(in_sum), .in_overflow(in_overflow), .in_i(in_i),
    .in_flag_next(in_flag_next), .in_valid(in_valid), .out_data(out_data0),
    .out_overflow(out_overflow0), .out_i(out_i0), .out_valid(out_valid0),
    .out_ready(out_ready), .count(count0), .full(full0), .drop_err(drop_err0),
    .clr_err(clr_err), .drop_cnt(drop_cnt0));

  typedef struct {
    logic [31:0] sum;
    logic        ov;
    logic [2:0]  idx;
  } item_t;

  item_t q[$];
  bit    m_err = 1'b0;
  int    m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of raw results with drop accounting, advanced at each edge.
  always @(posedge clk) begin
    bit    m_pop, m_res, m_full, m_drop;
    item_t it;
    if (rst) begin
      q.delete();
      m_err = 1'b0;
      m_cnt = 0;
    end else begin
      m_pop  = (q.size() > 0) && out_ready;
      m_res  = in_valid && !in_flag_next;
      m_full = (q.size() == DEPTH);
      m_drop = m_res && m_full && !m_pop;
      if (m_pop) void'(q.pop_front());
      if (m_res && !m_drop) begin
        it.sum = in_sum; it.ov = in_overflow; it.idx = in_i;
        q.push_back(it);
      end
      if (clr_err) begin
        m_err = m_drop;
        m_cnt = m_drop ? 1 : 0;
      end else if (m_drop) begin
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  end

  // Compare both instances against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid",     out_valid,  q.size() != 0);
      chk("valid0",    out_valid0, q.size() != 0);
      chk("count",     count,      q.size());
      chk("count0",    count0,     q.size());
      chk("full",      full,       q.size() == DEPTH);
      chk("drop_err",  drop_err,   m_err);
      chk("drop_err0", drop_err0,  m_err);
      chk("drop_cnt",  drop_cnt,   m_cnt);
      chk("drop_cnt0", drop_cnt0,  m_cnt);
      if (q.size() != 0) begin
        chk("data",  out_data,     q[0].ov ? 32'h7FFF_FFFF : q[0].sum);
        chk("data0", out_data0,    q[0].sum);
        chk("ov",    out_overflow, q[0].ov);
        chk("ov0",   out_overflow0, q[0].ov);
        chk("idx",   out_i,        q[0].idx);
        chk("idx0",  out_i0,       q[0].idx);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] s, input logic ov, input logic [2:0] idx);
    in_valid = 1'b1; in_flag_next = 1'b0; in_sum = s; in_overflow = ov; in_i = idx;
    tick();
    in_valid = 1'b0; in_overflow = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_sum = '0; in_overflow = 1'b0; in_i = '0; in_flag_next = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    tick(); tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_data",  out_data, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: single result visible one cycle after push
    put(32'h0000_1234, 1'b0, 3'd3);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data",  out_data, 32'h0000_1234);
    chk("t1_count", count, 3'd1);
    chk("t1_idx",   out_i, 3'd3);
    drain();

    // 2: recirculating items are not results
    in_valid = 1'b1; in_flag_next = 1'b1; in_sum = 32'hDEAD;
    tick(); tick(); tick();
    in_valid = 1'b0; in_flag_next = 1'b0;
    chk("t2_count", count, 3'd0);
    chk("t2_valid", out_valid, 1'b0);

    // 3: saturation on overflow
    put(32'h8000_0001, 1'b1, 3'd5);
    chk("t3_sat",   out_data, 32'h7FFF_FFFF);
    chk("t3_ov",    out_overflow, 1'b1);
    chk("t3_raw",   out_data0, 32'h8000_0001);
    drain();

    // 4: overfill by two, then pop in order
    for (int k = 1; k <= 6; k++) put(32'(k), 1'b0, 3'(k));
    chk("t4_full",  full, 1'b1);
    chk("t4_err",   drop_err, 1'b1);
    chk("t4_cnt",   drop_cnt, 8'd2);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t4_pop", out_data, 32'(k));
      tick();
    end
    out_ready = 1'b0;
    chk("t4_empty", count, 3'd0);

    // clear, then clear coinciding with a drop
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("clr_err", drop_err, 1'b0);
    chk("clr_cnt", drop_cnt, 8'd0);
    for (int k = 0; k < 4; k++) put(32'h10 + 32'(k), 1'b0, 3'd1);
    clr_err = 1'b1;
    put(32'h99, 1'b0, 3'd2);
    clr_err = 1'b0;
    chk("clrdrop_err", drop_err, 1'b1);
    chk("clrdrop_cnt", drop_cnt, 8'd1);

    // 5: full FIFO streaming push+pop every cycle
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_sum = 32'd100 + 32'(k); in_i = 3'(k);
      tick();
      chk("t5_count", count, 3'd4);
    end
    in_valid = 1'b0;
    chk("t5_cnt", drop_cnt, 8'd1);
    chk("t5_head", out_data, 32'd106);
    drain();

    // drop counter saturation
    for (int k = 0; k < 4; k++) put(32'(k), 1'b0, 3'd0);
    in_valid = 1'b1;
    for (int k = 0; k < 260; k++) tick();
    in_valid = 1'b0;
    chk("sat_cnt", drop_cnt, 8'd255);
    drain();

    // 6: reset mid-stream discards queued results
    for (int k = 0; k < 3; k++) put(32'h50 + 32'(k), 1'b0, 3'd4);
    chk("t6_pre", count, 3'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_count", count, 3'd0);
    chk("t6_cnt",   drop_cnt, 8'd0);
    put(32'h77, 1'b0, 3'd6);
    chk("t6_next_valid", out_valid, 1'b1);
    chk("t6_next_data",  out_data, 32'h77);
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
